sliced_cla_adder: RTL

SLICED_CLA_ADDER -- requirements
Module: sliced_cla_adder

---
 rtl/sliced_cla_adder_pkg.sv | 17 +
 rtl/carry_look_ahead.sv | 26 ++
 rtl/sliced_cla_adder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sliced_cla_adder_pkg.sv
// Shared types and sizing for the slice-serial carry-look-ahead adder.
// Slices are 4 bits wide, so the slice count is the operand width divided by four.
package sliced_cla_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int SLICE_W = 4;

   function automatic int slice_count(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/carry_look_ahead.sv
// 4-bit carry-look-ahead unit: per-bit carries plus group propagate/generate.
// Purely combinational; no handshake.
module carry_look_ahead (
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       c_in,
   output logic [3:0] c,
   output logic       c_out,
   output logic       p_out,
   output logic       g_out
);

   // c[i] is the carry out of bit i, each flattened to two logic levels.
   assign c[0] = g[0] | (p[0] & c_in);
   assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
   assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_in);
   assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);

   assign c_out = c[3];
   assign p_out = &p;
   assign g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/sliced_cla_adder.sv
// Adds two WIDTH-bit operands one 4-bit CLA slice per cycle; result after WIDTH/4 cycles.
// Accepts only in IDLE; result held in DONE until out_ready, inputs ignored meanwhile.
module sliced_cla_adder
   import sliced_cla_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NSLICE = slice_count(WIDTH);
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_e             state_q, state_d;
   logic [KW-1:0]      k_q, k_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               c_out_q, c_out_d;
   logic               ovf_q, ovf_d;

   logic [SLICE_W-1:0] slice_p, slice_g, slice_sum;
   logic [SLICE_W-1:0] cla_c;
   logic               cla_c_out;
   logic               cla_p_unused, cla_g_unused;
   logic               last_slice;

   assign slice_p    = a_q[SLICE_W*int'(k_q) +: SLICE_W] ^ b_q[SLICE_W*int'(k_q) +: SLICE_W];
   assign slice_g    = a_q[SLICE_W*int'(k_q) +: SLICE_W] & b_q[SLICE_W*int'(k_q) +: SLICE_W];
   assign slice_sum  = slice_p ^ {cla_c[SLICE_W-2:0], carry_q};
   assign last_slice = (k_q == KW'(NSLICE - 1));

   carry_look_ahead u_cla (
      .p     (slice_p),
      .g     (slice_g),
      .c_in  (carry_q),
      .c     (cla_c),
      .c_out (cla_c_out),
      .p_out (cla_p_unused),
      .g_out (cla_g_unused)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      c_out_d   = c_out_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
               k_d     = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            acc_d[SLICE_W*int'(k_q) +: SLICE_W] = slice_sum;
            carry_d = cla_c_out;
            k_d     = k_q + KW'(1);
            if (last_slice) begin
               // Output registers change only here, so the result is never partial.
               sum_d   = acc_d;
               c_out_d = cla_c_out;
               ovf_d   = cla_c[SLICE_W-2] ^ cla_c[SLICE_W-1];
               k_d     = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule
